// File: rtl/pseudorandom_generator_if.sv
// Start/done byte-request bus for pseudorandom_generator.
// PRG_STATE_OUT_EN adds the lfsr_state/busy observation signals.
interface pseudorandom_generator_if;
  logic        start;
  logic [31:0] in_seed;
  logic [7:0]  value;
  logic        done;
`ifdef PRG_STATE_OUT_EN
  logic [31:0] lfsr_state;
  logic        busy;

  modport master (output start, in_seed, input value, done, lfsr_state, busy);
  modport slave  (input start, in_seed, output value, done, lfsr_state, busy);
`else
  modport master (output start, in_seed, input value, done);
  modport slave  (input start, in_seed, output value, done);
`endif
endinterface

// File: rtl/pseudorandom_generator.sv
// Seeded 32-bit Galois LFSR emitting one byte per start/done request.
// Optional macro PRG_STATE_OUT_EN exposes lfsr_state and busy on the bus.
module pseudorandom_generator #(
  parameter int          STEPS    = 8,
  parameter logic [31:0] TAPS     = 32'h80200003,
  parameter logic [31:0] ZERO_SUB = 32'h00000001
) (
  input logic                      clk,
  input logic                      rst,
  pseudorandom_generator_if.slave  bus
);

  localparam logic [5:0] LAST = 6'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] lfsr_next;
  logic [31:0] seed_eff;
  logic        seeded;
  logic [5:0]  count;
  logic [7:0]  value;
  logic        done;

  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) lfsr_next = lfsr_next ^ TAPS;
  end

  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (bus.in_seed == 32'h0) ? ZERO_SUB : bus.in_seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= 32'h0;
      seeded <= 1'b0;
      count  <= 6'd0;
      value  <= 8'h00;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            count <= 6'd0;
            state <= RUN;
            if (!seeded) begin
              lfsr   <= seed_eff;
              seeded <= 1'b1;
            end
          end
        end
        RUN: begin
          lfsr  <= lfsr_next;
          count <= count + 6'd1;
          if (count == LAST) begin
            value <= lfsr_next[7:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.value = value;
  assign bus.done  = done;

`ifdef PRG_STATE_OUT_EN
  assign bus.lfsr_state = lfsr;
  assign bus.busy       = (state == RUN) || (state == DONE);
`endif

endmodule

// File: tb/tb_pseudorandom_generator.sv
// Self-checking bench for pseudorandom_generator: vector table, hand-written
// corner sequences and randomized requests against a sequence-level model.
module tb_pseudorandom_generator;

  localparam int          STEPS = 8;
  localparam logic [31:0] TAPS  = 32'h80200003;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pseudorandom_generator_if prg ();

  pseudorandom_generator dut (.clk(clk), .rst(rst), .bus(prg));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the generator as a sequence of LFSR states, seeded lazily.
  logic [31:0] m_lfsr;
  bit          m_seeded;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] half;
    half = s / 2;
    return (s % 2 == 1) ? (half ^ TAPS) : half;
  endfunction

  function automatic logic [7:0] m_request(input logic [31:0] seed);
    if (!m_seeded) begin
      m_lfsr   = (seed == 0) ? 32'd1 : seed;
      m_seeded = 1'b1;
    end
    for (int i = 0; i < STEPS; i++) m_lfsr = m_step(m_lfsr);
    return m_lfsr[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    prg.start = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    m_seeded = 1'b0;
  endtask

  // One request; hold=1 keeps start high through RUN and the DONE-leaving edge.
  task automatic request(input string tag, input bit hold, output logic [7:0] got);
    logic [7:0] exp;
    logic [7:0] prev;
    int         edges;
    bit         stable;
    exp    = m_request(prg.in_seed);
    prev   = prg.value;
    stable = 1'b1;
    @(negedge clk);
    prg.start = 1'b1;
    @(posedge clk);
    #1 if (!hold) prg.start = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (!prg.done && prg.value !== prev) stable = 1'b0;
    end while (!prg.done && edges < 30);
    check({tag, "_latency"}, edges, STEPS + 1);
    check({tag, "_value"}, prg.value, exp);
    check({tag, "_hold_before"}, stable, 1);
    got = prg.value;
    @(negedge clk);
    if (hold) prg.start = 1'b0;
    check({tag, "_done_1cyc"}, prg.done, 0);
    check({tag, "_value_kept"}, prg.value, exp);
    // Nothing must start after the request ends.
    repeat (STEPS + 3) @(negedge clk);
    check({tag, "_no_extra"}, prg.done, 0);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [31:0] seed2;
    int          nreq;
    bit          hold;
    bit          has_exp;
    logic [7:0]  first_exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] got;
    logic [7:0] prev_v;
    bit         prev_d;
    int         last_pulse;
    int         pulses;
    bit         stable;

    vecs[0] = '{32'h00000001, 32'hDEADBEEF, 3, 1'b0, 1'b1, 8'h02};
    vecs[1] = '{32'h00000000, 32'h12345678, 2, 1'b1, 1'b1, 8'h02};
    vecs[2] = '{32'hDEADBEEF, 32'h00000000, 3, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 2, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 2, 1'b1, 1'b0, 8'h00};

    prg.start   = 1'b0;
    prg.in_seed = 32'h0;
    m_seeded    = 1'b0;

    // Reset then idle.
    #2 rst = 1'b1;
    #1 check("reset_value", prg.value, 8'h00);
    check("reset_done", prg.done, 0);
    do_reset();
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (prg.value !== 8'h00 || prg.done !== 1'b0) stable = 1'b0;
    end
    check("idle_quiet", stable, 1);

    // Vector table: first request seeds, later ones continue despite seed changes.
    foreach (vecs[i]) begin
      do_reset();
      prg.in_seed = vecs[i].seed;
      request($sformatf("vec%0d_r0", i), vecs[i].hold, got);
      if (vecs[i].has_exp) check($sformatf("vec%0d_const", i), got, vecs[i].first_exp);
      prg.in_seed = vecs[i].seed2;
      for (int r = 1; r < vecs[i].nreq; r++)
        request($sformatf("vec%0d_r%0d", i, r), vecs[i].hold, got);
    end

    // Back-to-back: start held high for 100 cycles.
    do_reset();
    prg.in_seed = 32'h0BADF00D;
    @(negedge clk);
    prg.start  = 1'b1;
    prev_v     = prg.value;
    prev_d     = 1'b0;
    last_pulse = -1;
    pulses     = 0;
    for (int cyc = 0; cyc < 112; cyc++) begin
      @(negedge clk);
      if (prg.done) begin
        pulses++;
        check("b2b_value", prg.value, m_request(prg.in_seed));
        check("b2b_no_double", prev_d, 0);
        if (last_pulse >= 0) check("b2b_period", cyc - last_pulse, STEPS + 2);
        last_pulse = cyc;
      end else if (prg.value !== prev_v) begin
        check("b2b_value_stable", prg.value, prev_v);
      end
      prev_v = prg.value;
      prev_d = prg.done;
      if (cyc == 99) prg.start = 1'b0;
    end
    check("b2b_pulses", pulses, 10);

    // Mid-run reset aborts the request and forces a reseed.
    do_reset();
    prg.in_seed = 32'h13579BDF;
    request("mid_pre", 1'b0, got);
    @(negedge clk);
    prg.start = 1'b1;
    @(posedge clk);
    #1 prg.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid_rst_value", prg.value, 8'h00);
    check("mid_rst_done", prg.done, 0);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    m_seeded = 1'b0;
    stable   = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (prg.done !== 1'b0 || prg.value !== 8'h00) stable = 1'b0;
    end
    check("mid_no_done", stable, 1);
    prg.in_seed = 32'h2468ACE0;
    request("mid_reseed", 1'b0, got);

    // Randomized requests with random gaps, holds and seed churn.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      prg.in_seed = $urandom;
      for (int r = 0; r < 8; r++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        request($sformatf("rnd%0d_%0d", s, r), 1'($urandom_range(0, 1)), got);
        if ($urandom_range(0, 1) == 1) prg.in_seed = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
